// File: rtl/gm64_pkg.sv
// Shared types and address constants for the gm64 CPU-side blocks.
package gm64_pkg;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_REQ  = 2'd1,
    RS_WAIT = 2'd2
  } resp_state_e;

  typedef enum logic [3:0] {
    COLOR_BLACK       = 4'h0,
    COLOR_WHITE       = 4'h1,
    COLOR_RED         = 4'h2,
    COLOR_CYAN        = 4'h3,
    COLOR_PURPLE      = 4'h4,
    COLOR_GREEN       = 4'h5,
    COLOR_BLUE        = 4'h6,
    COLOR_YELLOW      = 4'h7,
    COLOR_ORANGE      = 4'h8,
    COLOR_BROWN       = 4'h9,
    COLOR_LIGHT_RED   = 4'hA,
    COLOR_DARK_GREY   = 4'hB,
    COLOR_GREY        = 4'hC,
    COLOR_LIGHT_GREEN = 4'hD,
    COLOR_LIGHT_BLUE  = 4'hE,
    COLOR_LIGHT_GREY  = 4'hF
  } Color;

  localparam logic [15:0] ADDR_BORDER     = 16'hD020;
  localparam logic [15:0] ADDR_BACKGROUND = 16'hD021;
  localparam logic [3:0]  IO_BASE         = 4'hD;
  localparam logic [15:0] VEC_RESET_LO    = 16'hFFFC;

  // True for both bytes of the reset vector ($FFFC and $FFFD).
  function automatic logic is_reset_vector(input logic [15:0] addr);
    return addr[15:1] == VEC_RESET_LO[15:1];
  endfunction

endpackage

// File: rtl/io_regs.sv
// $Dxxx page decode with the border/background colour registers.
// Latency: combinational read data; registers load on the clock after access.
// Backpressure: none, always accepts an access.
module io_regs
  import gm64_pkg::*;
(
  input  logic        clkSys,
  input  logic        reset,
  input  logic        access,
  input  logic [15:0] ab,
  input  logic        we,
  input  logic [3:0]  wdata,
  output logic        hit,
  output logic [7:0]  rdata,
  output logic [3:0]  border,
  output logic [3:0]  background
);

  assign hit = (ab[15:12] == IO_BASE);

  // Unimplemented I/O locations float high, as on the real bus.
  always_comb begin
    rdata = 8'hFF;
    if (ab == ADDR_BORDER)
      rdata = {4'hF, border};
    else if (ab == ADDR_BACKGROUND)
      rdata = {4'hF, background};
  end

  always_ff @(posedge clkSys) begin
    if (!reset) begin
      border     <= COLOR_LIGHT_BLUE;
      background <= COLOR_BLUE;
    end else if (access && we) begin
      if (ab == ADDR_BORDER)
        border <= wdata;
      else if (ab == ADDR_BACKGROUND)
        background <= wdata;
    end
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// Answers 6502 bus cycles: local vector/colour registers, everything else via memCtrl.
// Latency: local 1 cycle after phi0 edge; PSRAM strobe 1 cycle after edge plus busy stalls.
// Backpressure: strobe held off while i_busy; phi0 edges during a transaction are dropped and counted.
module cpu_bus_responder
  import gm64_pkg::*;
#(
  parameter logic [23:0] PSRAM_BASE      = 24'h000000,
  parameter bit          VECTOR_OVERRIDE = 1'b1,
  parameter logic [15:0] RESET_VECTOR    = 16'h0300
) (
  input  logic        clkSys,
  input  logic        reset,
  input  logic        i_phi0,
  input  logic [15:0] i_ab,
  input  logic        i_we,
  input  logic [7:0]  i_do,
  output logic [7:0]  o_di,
  output logic        o_cs,
  output logic        o_write,
  output logic [23:0] o_address,
  output logic [7:0]  o_dataToWrite,
  input  logic        i_busy,
  input  logic        i_dataReady,
  input  logic [7:0]  i_dataRead,
  output logic [3:0]  o_border,
  output logic [3:0]  o_background,
  output logic        o_overrun,
  output logic [7:0]  o_overrunCnt
);

  resp_state_e state;
  logic        phi0_prev;
  logic        phi0_edge;
  logic        idle_edge;
  logic        io_hit;
  logic [7:0]  io_rdata;
  logic        vec_hit;
  logic [7:0]  vec_rdata;

  assign phi0_edge = i_phi0 & ~phi0_prev;
  assign idle_edge = phi0_edge && (state == RS_IDLE);

  assign vec_hit   = VECTOR_OVERRIDE && !i_we && is_reset_vector(i_ab);
  assign vec_rdata = i_ab[0] ? RESET_VECTOR[15:8] : RESET_VECTOR[7:0];

  // Strobe follows live busy so it can never coincide with it; reset kills it immediately.
  assign o_cs = reset && (state == RS_REQ) && !i_busy;

  io_regs u_io_regs (
    .clkSys     (clkSys),
    .reset      (reset),
    .access     (idle_edge),
    .ab         (i_ab),
    .we         (i_we),
    .wdata      (i_do[3:0]),
    .hit        (io_hit),
    .rdata      (io_rdata),
    .border     (o_border),
    .background (o_background)
  );

  always_ff @(posedge clkSys) begin
    if (!reset) begin
      state         <= RS_IDLE;
      phi0_prev     <= 1'b0;
      o_di          <= 8'h00;
      o_write       <= 1'b0;
      o_address     <= 24'h000000;
      o_dataToWrite <= 8'h00;
      o_overrun     <= 1'b0;
      o_overrunCnt  <= 8'h00;
    end else begin
      phi0_prev <= i_phi0;

      case (state)
        RS_IDLE: begin
          if (phi0_edge) begin
            if (io_hit) begin
              if (!i_we)
                o_di <= io_rdata;
            end else if (vec_hit) begin
              o_di <= vec_rdata;
            end else begin
              // Request fields double as the capture registers and hold until the next cycle.
              state         <= RS_REQ;
              o_write       <= i_we;
              o_address     <= PSRAM_BASE + {8'h00, i_ab};
              o_dataToWrite <= i_do;
            end
          end
        end
        RS_REQ: begin
          if (!i_busy)
            state <= o_write ? RS_IDLE : RS_WAIT;
        end
        RS_WAIT: begin
          if (i_dataReady) begin
            o_di  <= i_dataRead;
            state <= RS_IDLE;
          end
        end
        default: state <= RS_IDLE;
      endcase

      if (phi0_edge && (state != RS_IDLE)) begin
        o_overrun <= 1'b1;
        if (o_overrunCnt != 8'hFF)
          o_overrunCnt <= o_overrunCnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/cpu_bus_responder.md
# cpu_bus_responder

Responder for the 6502 core's memory bus: answers every CPU bus cycle, reads or writes, on behalf of the rest of the system. It sits between `cpu` (AB/DI/DO/WE) and `memCtrl`. It serves the reset vector and the $D020/$D021 colour registers locally, and forwards all other accesses to PSRAM through memCtrl's request/ready handshake. Everything runs on `clkSys`; `clkPhi0` enters as a sampled level.

## Interface
- `PSRAM_BASE`, 24'h000000: PSRAM byte address of CPU address $0000.
- `VECTOR_OVERRIDE`, 1: when 1, reads of $FFFC/$FFFD are answered locally.
- `RESET_VECTOR`, 16'h0300: value returned for $FFFC (low byte) and $FFFD (high byte).

Ports:
- `clkSys`  in  1  system clock; sole clock.
- `reset`  in  1  synchronous, active-low reset.
- `i_phi0`  in  1  CPU phase clock, sampled on `clkSys`.
- `i_ab`  in  16  CPU address bus.
- `i_we`  in  1  CPU write enable (1 = write).
- `i_do`  in  8  CPU data out, used on writes.
- `o_di`  out  8  data to CPU DI; holds its value between reads.
- `o_cs`  out  1  one-cycle request strobe to memCtrl.
- `o_write`  out  1  request type, valid while `o_cs`=1.
- `o_address`  out  24  request address, `PSRAM_BASE + i_ab`, modulo 2^24.
- `o_dataToWrite`  out  8  write data.
- `i_busy`  in  1  memCtrl busy.
- `i_dataReady`  in  1  one-cycle pulse; read data valid.
- `i_dataRead`  in  8  read data from memCtrl.
- `o_border`  out  4  $D020 colour register.
- `o_background`  out  4  $D021 colour register.
- `o_overrun`  out  1  sticky: a phi0 edge arrived while a request was still outstanding.
- `o_overrunCnt`  out  8  saturating count of overruns.

## Operation
- Edge detect: `phi0Edge = i_phi0 & !phi0Prev`, where `phi0Prev` is registered from `i_phi0`. On an edge, `i_ab`, `i_we` and `i_do` are captured.
- State machine:
  - IDLE, on `phi0Edge`, routes the captured cycle:
    - Write to $D020 or $D021: load `i_do[3:0]` into `o_border` / `o_background`; stay in IDLE.
    - Read of $D020 or $D021: `o_di` = {4'hF, register}; stay in IDLE.
    - Any other $D000–$DFFF access: writes are ignored; reads return 8'hFF.
    - Read of $FFFC or $FFFD with `VECTOR_OVERRIDE`: return the vector byte; stay in IDLE.
    - Everything else: go to REQ.
  - REQ waits while `i_busy`=1. At the first cycle with `i_busy`=0 it drives `o_cs`=1 with the captured `o_write`, `o_address` and `o_dataToWrite`. A write then returns to IDLE (posted write). A read goes to WAIT.
  - WAIT, on `i_dataReady`, latches `i_dataRead` into `o_di` and goes to IDLE.
- Overrun: a `phi0Edge` seen in REQ or WAIT sets `o_overrun` and increments `o_overrunCnt`, which saturates at 255. The new bus cycle is dropped; the outstanding transaction completes normally.
- `i_dataReady` outside WAIT is ignored.
- `o_address`, `o_write` and `o_dataToWrite` hold their values outside `o_cs`.

## Timing
- Reset values:
  - `o_di` = 8'h00; `o_cs` = 0; `o_write` = 0; `o_address` = 0; `o_dataToWrite` = 0.
  - `o_border` = 4'hE; `o_background` = 4'h6.
  - `o_overrun` = 0; `o_overrunCnt` = 0.
  - State = IDLE; `phi0Prev` = 0.
- Reset asserted mid-transaction: return to IDLE the next cycle; no further `o_cs`; a late `i_dataReady` is ignored.
- Local access latency: `o_di` or the register updates 1 cycle after `phi0Edge` is detected.
- PSRAM read latency: `o_cs` no earlier than 1 cycle after the edge, plus busy-stall cycles. `o_di` updates the cycle after `i_dataReady`.
- `o_cs` is never high for 2 consecutive cycles, and is never asserted while `i_busy`=1.
- Simultaneous `phi0Edge` and `i_dataReady` in WAIT: the read data is latched and the overrun is counted. The edge is still dropped.

## Structure
- Shared package `gm64_pkg`:
  - responder state enum (IDLE, REQ, WAIT);
  - constants `ADDR_BORDER` = 16'hD020, `ADDR_BACKGROUND` = 16'hD021, `IO_BASE` = 4'hD, `VEC_RESET_LO` = 16'hFFFC;
  - the existing `Color` enum.
- One natural sub-module: `io_regs`, holding the $D0xx decode and the colour registers. Everything else stays in `cpu_bus_responder`.

## Test plan
- Reset vector: release reset, phi0 edges with reads of $FFFC then $FFFD -> `o_di` = 8'h00, then 8'h03; `o_cs` never asserted.
- Border write: write $D020 with `i_do` = 8'h25 -> `o_border` = 4'h5. A following read of $D020 -> `o_di` = 8'hF5. No memCtrl request.
- PSRAM read, `PSRAM_BASE` = 24'h010000: read $0300, `i_busy` held 3 cycles, then `i_dataReady` with 8'h8D.
  - `o_cs` pulses once with `o_address` = 24'h010300 and `o_write` = 0.
  - `o_di` = 8'h8D the next cycle.
- Posted write: write $1234 with 8'hAA -> a single `o_cs` with `o_write` = 1 and `o_dataToWrite` = 8'hAA; state is IDLE the next cycle.
- Overrun: hold back `i_dataReady` across 2 phi0 edges -> `o_overrun` = 1, `o_overrunCnt` = 2. A late `i_dataReady` is still latched into `o_di`. Driving 300 overruns leaves `o_overrunCnt` = 255.
- Reset mid-read: assert reset during WAIT, then pulse `i_dataReady` -> `o_di` stays 8'h00, no `o_cs`, and all outputs are at their reset values.
